// File: rtl/score_keeper.sv
// Whack-a-mole score keeper: key sync, press detect, score FSM.
// Feeds the hex score display and the mole generator.
module score_keeper #(
  parameter int NUM_HOLES = 4,
  parameter int MAX_SCORE = 99,
  parameter int PENALTY   = 1
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic                 Start,
  input  logic                 Game_Over,
  input  logic [NUM_HOLES-1:0] Mole_Mask,
  input  logic [NUM_HOLES-1:0] Key_N,
  output logic [7:0]           Score,
  output logic [7:0]           High_Score,
  output logic [NUM_HOLES-1:0] Whack,
  output logic                 Hit,
  output logic                 Miss,
  output logic [1:0]           State
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [7:0] MAX8 = 8'(MAX_SCORE);
  localparam logic [7:0] PEN8 = 8'(PENALTY);

  state_t state, state_d;

  logic [NUM_HOLES-1:0] s1, s2, prev;
  logic [NUM_HOLES-1:0] press, hitset;

  logic [7:0]           score_d, high_d;
  logic [NUM_HOLES-1:0] whack_d;
  logic                 hit_d, miss_d;

  // Two-flop synchronizer plus previous value; released is all-1.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      s1   <= '1;
      s2   <= '1;
      prev <= '1;
    end else begin
      s1   <= Key_N;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign press  = prev & ~s2;
  assign hitset = press & Mole_Mask;

  // State register.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= IDLE;
    else         state <= state_d;
  end

  // Next state; Game_Over wins over Start while playing.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (Start)     state_d = PLAY;
      PLAY:    if (Game_Over) state_d = DONE;
      DONE:    if (Start)     state_d = PLAY;
      default:                state_d = IDLE;
    endcase
  end

  // Score, high score and event pulses for the coming edge.
  always_comb begin
    score_d = Score;
    high_d  = High_Score;
    whack_d = '0;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (Start) score_d = 8'd0;
      end
      PLAY: begin
        if (Game_Over) begin
          if (Score > High_Score) high_d = Score;
        end else if (Start) begin
          score_d = 8'd0;
        end else if (|hitset) begin
          hit_d   = 1'b1;
          whack_d = hitset;
          score_d = (Score < MAX8) ? Score + 8'd1 : MAX8;
        end else if (|press) begin
          miss_d  = 1'b1;
          score_d = (Score >= PEN8) ? Score - PEN8 : 8'd0;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs; pulses last exactly one cycle.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      Score      <= 8'd0;
      High_Score <= 8'd0;
      Whack      <= '0;
      Hit        <= 1'b0;
      Miss       <= 1'b0;
    end else begin
      Score      <= score_d;
      High_Score <= high_d;
      Whack      <= whack_d;
      Hit        <= hit_d;
      Miss       <= miss_d;
    end
  end

  assign State = state;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: vector table, corner sequences,
// and random play against a key-history reference model.
module tb_score_keeper;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic       Start = 1'b0;
  logic       Game_Over = 1'b0;
  logic [3:0] Mole_Mask = 4'b0000;
  logic [3:0] Key_N = 4'b1111;
  logic [7:0] Score, High_Score;
  logic [3:0] Whack;
  logic       Hit, Miss;
  logic [1:0] State;

  score_keeper #(
    .NUM_HOLES(4),
    .MAX_SCORE(99),
    .PENALTY(1)
  ) dut (
    .Clock(Clock),
    .Resetn(Resetn),
    .Start(Start),
    .Game_Over(Game_Over),
    .Mole_Mask(Mole_Mask),
    .Key_N(Key_N),
    .Score(Score),
    .High_Score(High_Score),
    .Whack(Whack),
    .Hit(Hit),
    .Miss(Miss),
    .State(State)
  );

  always #5 Clock = ~Clock;

  int n_chk = 0;
  int n_fail = 0;

  // Reference: key value seen at the last three edges.
  logic [3:0] k1, k2, k3;
  int m_st, m_score, m_high;
  int m_hit, m_miss;
  logic [3:0] m_whack;

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    k1 = 4'hF; k2 = 4'hF; k3 = 4'hF;
    m_st = 0; m_score = 0; m_high = 0;
    m_hit = 0; m_miss = 0; m_whack = 4'h0;
  endtask

  // A press reaches the scoring logic three edges after the fall.
  task automatic model_step(input logic st, input logic go,
                            input logic [3:0] mask,
                            input logic [3:0] key);
    logic [3:0] pr, hs;
    pr = k3 & ~k2;
    hs = pr & mask;
    k3 = k2; k2 = k1; k1 = key;
    m_hit = 0; m_miss = 0; m_whack = 4'h0;
    if (m_st == 1) begin
      if (go) begin
        m_st = 2;
        if (m_score > m_high) m_high = m_score;
      end else if (st) begin
        m_score = 0;
      end else if (hs != 0) begin
        m_hit = 1;
        m_whack = hs;
        m_score = (m_score + 1 > 99) ? 99 : m_score + 1;
      end else if (pr != 0) begin
        m_miss = 1;
        m_score = (m_score - 1 < 0) ? 0 : m_score - 1;
      end
    end else if (st) begin
      m_st = 1;
      m_score = 0;
    end
  endtask

  task automatic cmp_model();
    chk("score", Score, m_score);
    chk("high", High_Score, m_high);
    chk("state", State, m_st);
    chk("hit", Hit, m_hit);
    chk("miss", Miss, m_miss);
    chk("whack", Whack, m_whack);
  endtask

  task automatic cyc(input logic st, input logic go,
                     input logic [3:0] mask,
                     input logic [3:0] key);
    Start = st; Game_Over = go;
    Mole_Mask = mask; Key_N = key;
    @(posedge Clock);
    model_step(st, go, mask, key);
    #1;
    cmp_model();
  endtask

  typedef struct {
    logic       st, go;
    logic [3:0] mask, key;
    int         score;
    logic       hit, miss;
    logic [3:0] whack;
    int         state;
  } vec_t;

  vec_t tbl[21];
  int hits;
  logic [3:0] key;

  initial begin
    tbl[0]  = '{1, 0, 4'b0000, 4'b1111, 0, 0, 0, 4'b0000, 1};
    tbl[1]  = '{0, 0, 4'b0010, 4'b1101, 0, 0, 0, 4'b0000, 1};
    tbl[2]  = '{0, 0, 4'b0010, 4'b1101, 0, 0, 0, 4'b0000, 1};
    tbl[3]  = '{0, 0, 4'b0010, 4'b1101, 1, 1, 0, 4'b0010, 1};
    tbl[4]  = '{0, 0, 4'b0010, 4'b1101, 1, 0, 0, 4'b0000, 1};
    tbl[5]  = '{0, 0, 4'b0010, 4'b1111, 1, 0, 0, 4'b0000, 1};
    tbl[6]  = '{0, 0, 4'b0010, 4'b1111, 1, 0, 0, 4'b0000, 1};
    tbl[7]  = '{0, 0, 4'b0010, 4'b1101, 1, 0, 0, 4'b0000, 1};
    tbl[8]  = '{0, 0, 4'b0010, 4'b1101, 1, 0, 0, 4'b0000, 1};
    tbl[9]  = '{0, 0, 4'b0010, 4'b1101, 2, 1, 0, 4'b0010, 1};
    tbl[10] = '{0, 0, 4'b0001, 4'b0111, 2, 0, 0, 4'b0000, 1};
    tbl[11] = '{0, 0, 4'b0001, 4'b0111, 2, 0, 0, 4'b0000, 1};
    tbl[12] = '{0, 0, 4'b0001, 4'b0111, 1, 0, 1, 4'b0000, 1};
    tbl[13] = '{0, 0, 4'b0001, 4'b1111, 1, 0, 0, 4'b0000, 1};
    tbl[14] = '{0, 0, 4'b0001, 4'b0111, 1, 0, 0, 4'b0000, 1};
    tbl[15] = '{0, 0, 4'b0001, 4'b0111, 1, 0, 0, 4'b0000, 1};
    tbl[16] = '{0, 0, 4'b0001, 4'b1111, 0, 0, 1, 4'b0000, 1};
    tbl[17] = '{0, 0, 4'b0001, 4'b0111, 0, 0, 0, 4'b0000, 1};
    tbl[18] = '{0, 0, 4'b0001, 4'b0111, 0, 0, 0, 4'b0000, 1};
    tbl[19] = '{0, 0, 4'b0001, 4'b0111, 0, 0, 1, 4'b0000, 1};
    tbl[20] = '{0, 0, 4'b0001, 4'b1111, 0, 0, 0, 4'b0000, 1};

    model_reset();
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_score", Score, 0);
    chk("rst_state", State, 0);
    chk("rst_pulse", {Hit, Miss, Whack}, 0);
    @(negedge Clock);
    Resetn = 1'b1;
    @(posedge Clock);
    #1;

    // Idle with keys released: nothing may move.
    for (int i = 0; i < 10; i++) cyc(0, 0, 4'hF, 4'hF);

    // Hand-computed vectors: hit latency, re-press, misses at zero.
    for (int i = 0; i < 21; i++) begin
      cyc(tbl[i].st, tbl[i].go, tbl[i].mask, tbl[i].key);
      chk($sformatf("v%0d_score", i), Score, tbl[i].score);
      chk($sformatf("v%0d_hit", i), Hit, tbl[i].hit);
      chk($sformatf("v%0d_miss", i), Miss, tbl[i].miss);
      chk($sformatf("v%0d_whack", i), Whack, tbl[i].whack);
      chk($sformatf("v%0d_state", i), State, tbl[i].state);
      chk($sformatf("v%0d_high", i), High_Score, 0);
    end

    // 100 hits from zero: saturates at 99, last hit still pulses.
    hits = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(0, 0, 4'b0001, 4'b1110);
      hits += int'(Hit);
      cyc(0, 0, 4'b0001, 4'b1111);
      hits += int'(Hit);
    end
    repeat (3) begin
      cyc(0, 0, 4'b0001, 4'b1111);
      hits += int'(Hit);
    end
    chk("sat_hits", hits, 100);
    chk("sat_score", Score, 99);
    cyc(0, 1, 4'b0000, 4'b1111);
    chk("go_state", State, 2);
    chk("go_high", High_Score, 99);
    cyc(1, 0, 4'b0000, 4'b1111);
    chk("restart_score", Score, 0);
    chk("restart_high", High_Score, 99);

    // Game_Over in the same cycle as a valid hit press.
    repeat (3) cyc(0, 0, 4'b0001, 4'b1110);
    chk("pre_score", Score, 1);
    repeat (2) cyc(0, 0, 4'b0001, 4'b1111);
    repeat (2) cyc(0, 0, 4'b0001, 4'b1110);
    cyc(0, 1, 4'b0001, 4'b1110);
    chk("gohit_hit", Hit, 0);
    chk("gohit_score", Score, 1);
    chk("gohit_state", State, 2);
    cyc(1, 0, 4'b0000, 4'b1111);
    cyc(1, 1, 4'b0000, 4'b1111);
    chk("startgo_state", State, 2);

    // Two simultaneous hits score once, then async reset mid-play.
    cyc(1, 0, 4'b1111, 4'b1111);
    repeat (2) cyc(0, 0, 4'b1111, 4'b1111);
    repeat (3) cyc(0, 0, 4'b1111, 4'b1010);
    chk("dual_whack", Whack, 4'b0101);
    chk("dual_hit", Hit, 1);
    chk("dual_score", Score, 1);
    Key_N = 4'b1111;
    #3;
    Resetn = 1'b0;
    #1;
    chk("arst_score", Score, 0);
    chk("arst_high", High_Score, 0);
    chk("arst_state", State, 0);
    chk("arst_pulse", {Hit, Miss, Whack}, 0);
    model_reset();
    @(negedge Clock);
    Resetn = 1'b1;

    // Random play against the reference model.
    key = 4'hF;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(2) == 0) key[$urandom_range(3)] ^= 1'b1;
      cyc($urandom_range(39) == 0, $urandom_range(29) == 0,
          4'($urandom), key);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
